// File: rtl/reg64_ctrl_pkg.sv
// Shared types and constants for the 64-bit register write arbiter.
package reg64_ctrl_pkg;

  localparam int unsigned REG_W = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_ACK
  } wr_state_t;

endpackage

// File: rtl/reg64_write_arbiter_if.sv
// Requester/register-bank bus of the write arbiter; master = requesters side, slave = arbiter.
interface reg64_write_arbiter_if
  import reg64_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_REGS = 6,
  parameter int unsigned ADDR_W   = 3
) ();

  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*ADDR_W-1:0] i_addr;
  logic [NUM_REQ*REG_W-1:0]  i_data;
  logic [NUM_REQ-1:0]        o_ack;
  logic                      o_err;
  logic [NUM_REGS-1:0]       o_wr;
  logic [REG_W-1:0]          o_wr_data;
  logic                      o_busy;

  modport master (
    output i_req, i_addr, i_data,
    input  o_ack, o_err, o_wr, o_wr_data, o_busy
  );

  modport slave (
    input  i_req, i_addr, i_data,
    output o_ack, o_err, o_wr, o_wr_data, o_busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts just after the last winner and wraps.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] idx
);

  logic found;

  // Outer loop walks priority order; inner loop keeps every index constant after unrolling.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && req[j] && (j == (32'(last) + i) % N)) begin
          grant[j] = 1'b1;
          idx      = IDXW'(j);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reg64_write_arbiter.sv
// Round-robin write arbiter driving one-hot write strobes and shared data into a 64-bit register bank.
module reg64_write_arbiter
  import reg64_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_REGS = 6,
  parameter int unsigned ADDR_W   = 3
) (
  input logic                  i_clk,
  input logic                  i_arst,
  reg64_write_arbiter_if.slave bus
);

  localparam int unsigned IDXW = $clog2(NUM_REQ);

  wr_state_t           state_q, state_d;
  logic [IDXW-1:0]     ptr_q, ptr_d;
  logic [IDXW-1:0]     win_idx_q, win_idx_d;
  logic [NUM_REQ-1:0]  win_oh_q, win_oh_d;
  logic                bad_q, bad_d;
  logic [NUM_REGS-1:0] wr_q, wr_d;
  logic [REG_W-1:0]    data_q, data_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  grant;
  logic [IDXW-1:0]     grant_idx;
  logic [ADDR_W-1:0]   addr_sel;
  logic [REG_W-1:0]    data_sel;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (bus.i_req),
    .last  (ptr_q),
    .grant (grant),
    .idx   (grant_idx)
  );

  // Strobe and data are registered on the grant edge so they appear during WRITE.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_idx_d = win_idx_q;
    win_oh_d  = win_oh_q;
    bad_d     = bad_q;
    wr_d      = '0;
    data_d    = data_q;
    ack_d     = '0;
    err_d     = 1'b0;
    addr_sel  = '0;
    data_sel  = '0;

    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        addr_sel = bus.i_addr[k*ADDR_W +: ADDR_W];
        data_sel = bus.i_data[k*REG_W +: REG_W];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|grant) begin
          state_d   = S_WRITE;
          win_idx_d = grant_idx;
          win_oh_d  = grant;
          bad_d     = (32'(addr_sel) >= NUM_REGS);
          data_d    = data_sel;
          // An out-of-range address matches no bit, leaving the strobe all-zero.
          for (int unsigned r = 0; r < NUM_REGS; r++) begin
            wr_d[r] = (32'(addr_sel) == r);
          end
        end
      end
      S_WRITE: begin
        state_d = S_ACK;
        ack_d   = win_oh_q;
        err_d   = bad_q;
      end
      S_ACK: begin
        state_d = S_IDLE;
        ptr_d   = win_idx_q;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_idx_q <= '0;
      win_oh_q  <= '0;
      bad_q     <= 1'b0;
      wr_q      <= '0;
      data_q    <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_idx_q <= win_idx_d;
      win_oh_q  <= win_oh_d;
      bad_q     <= bad_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.o_wr      = wr_q;
  assign bus.o_wr_data = data_q;
  assign bus.o_ack     = ack_q;
  assign bus.o_err     = err_q;
  assign bus.o_busy    = busy_q;

endmodule

// File: tb/tb_reg64_write_arbiter.sv
// Directed bench for reg64_write_arbiter: latency, round-robin order, range error, reset abort, withdrawal.
module tb_reg64_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg64_write_arbiter_if #(.NUM_REQ(4), .NUM_REGS(6), .ADDR_W(3)) bus ();

  reg64_write_arbiter #(.NUM_REQ(4), .NUM_REGS(6), .ADDR_W(3)) dut (
    .i_clk  (clk),
    .i_arst (rst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int unsigned k, input logic [2:0] a, input logic [63:0] d);
    bus.i_addr[k*3 +: 3]  = a;
    bus.i_data[k*64 +: 64] = d;
    bus.i_req[k]           = 1'b1;
  endtask

  // Grant edge then WRITE cycle check, then ACK cycle check; returns while in ACK.
  task automatic txn(input string tag, input int unsigned w, input logic [5:0] wr_exp,
                     input logic [63:0] d_exp, input logic err_exp);
    logic [3:0] ack_exp;
    ack_exp = 4'(1 << w);
    tick();
    chk({tag, ".wr"}, 64'(bus.o_wr), 64'(wr_exp));
    if (!err_exp) chk({tag, ".wr_data"}, bus.o_wr_data, d_exp);
    chk({tag, ".ack_in_write"}, 64'(bus.o_ack), 64'(4'b0000));
    chk({tag, ".busy_write"}, 64'(bus.o_busy), 64'(1'b1));
    tick();
    chk({tag, ".wr_in_ack"}, 64'(bus.o_wr), 64'(6'b000000));
    chk({tag, ".ack"}, 64'(bus.o_ack), 64'(ack_exp));
    chk({tag, ".err"}, 64'(bus.o_err), 64'(err_exp));
    chk({tag, ".busy_ack"}, 64'(bus.o_busy), 64'(1'b1));
  endtask

  task automatic idle_tick(input string tag);
    tick();
    chk({tag, ".ack_idle"}, 64'(bus.o_ack), 64'(4'b0000));
    chk({tag, ".err_idle"}, 64'(bus.o_err), 64'(1'b0));
    chk({tag, ".busy_idle"}, 64'(bus.o_busy), 64'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.i_req  = '0;
    bus.i_addr = '0;
    bus.i_data = '0;

    // Reset state, checked before any clock edge
    #2;
    chk("rst.wr", 64'(bus.o_wr), 64'(6'b0));
    chk("rst.ack", 64'(bus.o_ack), 64'(4'b0));
    chk("rst.err", 64'(bus.o_err), 64'(1'b0));
    chk("rst.busy", 64'(bus.o_busy), 64'(1'b0));
    chk("rst.wr_data", bus.o_wr_data, 64'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle.busy", 64'(bus.o_busy), 64'(1'b0));

    // 1. Single write from requester 0
    set_slot(0, 3'd2, 64'hDEAD_BEEF_0123_4567);
    txn("t1", 0, 6'b000100, 64'hDEAD_BEEF_0123_4567, 1'b0);
    bus.i_req[0] = 1'b0;
    idle_tick("t1");
    tick();
    chk("t1.no_req_busy", 64'(bus.o_busy), 64'(1'b0));
    chk("t1.no_req_wr", 64'(bus.o_wr), 64'(6'b0));

    // 3. Out-of-range address from requester 2
    set_slot(2, 3'd7, 64'h1111_2222_3333_4444);
    txn("t3", 2, 6'b000000, 64'h0, 1'b1);
    bus.i_req[2] = 1'b0;
    idle_tick("t3");

    // 6. Requester 3 held high, new addr/data after each ack
    set_slot(3, 3'd5, 64'hA5A5_0000_0000_0001);
    txn("t6a", 3, 6'b100000, 64'hA5A5_0000_0000_0001, 1'b0);
    set_slot(3, 3'd1, 64'hA5A5_0000_0000_0002);
    idle_tick("t6a");
    txn("t6b", 3, 6'b000010, 64'hA5A5_0000_0000_0002, 1'b0);
    set_slot(3, 3'd4, 64'hA5A5_0000_0000_0003);
    idle_tick("t6b");
    txn("t6c", 3, 6'b010000, 64'hA5A5_0000_0000_0003, 1'b0);
    bus.i_req[3] = 1'b0;
    idle_tick("t6c");

    // 2. Full contention; last winner was 3 so order is 0,1,2,3
    set_slot(0, 3'd0, 64'h0000_0000_0000_00C0);
    set_slot(1, 3'd1, 64'h0000_0000_0000_00C1);
    set_slot(2, 3'd2, 64'h0000_0000_0000_00C2);
    set_slot(3, 3'd3, 64'h0000_0000_0000_00C3);
    txn("t2.g0", 0, 6'b000001, 64'h0000_0000_0000_00C0, 1'b0);
    bus.i_req[0] = 1'b0;
    idle_tick("t2.g0");
    txn("t2.g1", 1, 6'b000010, 64'h0000_0000_0000_00C1, 1'b0);
    bus.i_req[1] = 1'b0;
    idle_tick("t2.g1");
    txn("t2.g2", 2, 6'b000100, 64'h0000_0000_0000_00C2, 1'b0);
    bus.i_req[2] = 1'b0;
    idle_tick("t2.g2");
    txn("t2.g3", 3, 6'b001000, 64'h0000_0000_0000_00C3, 1'b0);
    bus.i_req[3] = 1'b0;
    idle_tick("t2.g3");
    // Re-raise 0 and 3 with last winner 3: order 0 then 3
    set_slot(0, 3'd5, 64'h0000_0000_0000_00D0);
    set_slot(3, 3'd4, 64'h0000_0000_0000_00D3);
    txn("t2.r0", 0, 6'b100000, 64'h0000_0000_0000_00D0, 1'b0);
    bus.i_req[0] = 1'b0;
    idle_tick("t2.r0");
    txn("t2.r3", 3, 6'b010000, 64'h0000_0000_0000_00D3, 1'b0);
    bus.i_req[3] = 1'b0;
    idle_tick("t2.r3");

    // 5. Requester 1 withdraws right after being latched
    set_slot(1, 3'd0, 64'h5555_6666_7777_8888);
    tick();
    bus.i_req[1] = 1'b0;
    chk("t5.wr", 64'(bus.o_wr), 64'(6'b000001));
    chk("t5.wr_data", bus.o_wr_data, 64'h5555_6666_7777_8888);
    tick();
    chk("t5.ack", 64'(bus.o_ack), 64'(4'b0010));
    chk("t5.err", 64'(bus.o_err), 64'(1'b0));
    idle_tick("t5");

    // 4. Reset during WRITE; last winner 1 so 0 wins among {0,1}
    set_slot(0, 3'd2, 64'h0000_0000_0000_0A0A);
    set_slot(1, 3'd3, 64'h0000_0000_0000_0B0B);
    tick();
    chk("t4.wr_before_rst", 64'(bus.o_wr), 64'(6'b000100));
    rst = 1'b1;
    #1;
    chk("t4.wr_async", 64'(bus.o_wr), 64'(6'b0));
    chk("t4.busy_async", 64'(bus.o_busy), 64'(1'b0));
    tick();
    chk("t4.ack_in_rst", 64'(bus.o_ack), 64'(4'b0));
    chk("t4.wr_in_rst", 64'(bus.o_wr), 64'(6'b0));
    rst = 1'b0;
    // Pointer back to 0: search starts at 1, so requester 1 now wins
    txn("t4.g1", 1, 6'b001000, 64'h0000_0000_0000_0B0B, 1'b0);
    bus.i_req[1] = 1'b0;
    idle_tick("t4.g1");
    txn("t4.g0", 0, 6'b000100, 64'h0000_0000_0000_0A0A, 1'b0);
    bus.i_req[0] = 1'b0;
    idle_tick("t4.g0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
